// File: rtl/vga_sync_generator.sv
// vga_sync_generator
//   Generates VGA raster timing for the image generator and the DAC/connector.
//   A horizontal counter walks every pixel clock of a line. A vertical counter
//   advances once per line. Every output is registered from the current counter
//   values, so the outputs trail the counters by one clock.
//
// Ports
//   clk          in   1   pixel clock, all logic on posedge
//   reset        in   1   synchronous, active-high reset
//   h_sync       out  1   horizontal sync, active level H_POL
//   v_sync       out  1   vertical sync, active level V_POL
//   disp_ena     out  1   high inside the active display region
//   column       out  32  current pixel column, holds H_PIXELS-1 in blanking
//   row          out  32  current pixel row, holds V_PIXELS-1 in blanking
//   frame_start  out  1   one-clock pulse at pixel (0,0) of every frame

module vga_sync_generator #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_PULSE  = 96,
  parameter int unsigned H_BP     = 48,
  parameter bit          H_POL    = 1'b0,
  parameter int unsigned V_PIXELS = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_PULSE  = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          V_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        h_sync,
  output logic        v_sync,
  output logic        disp_ena,
  output logic [31:0] column,
  output logic [31:0] row,
  output logic        frame_start
);

  localparam int unsigned H_PERIOD     = H_PIXELS + H_FP + H_PULSE + H_BP;
  localparam int unsigned V_PERIOD     = V_PIXELS + V_FP + V_PULSE + V_BP;
  localparam int unsigned H_SYNC_START = H_PIXELS + H_FP;
  localparam int unsigned H_SYNC_END   = H_PIXELS + H_FP + H_PULSE;
  localparam int unsigned V_SYNC_START = V_PIXELS + V_FP;
  localparam int unsigned V_SYNC_END   = V_PIXELS + V_FP + V_PULSE;

  logic [31:0] h_cnt;
  logic [31:0] v_cnt;
  logic        h_last;
  logic        v_last;
  logic        h_active;
  logic        v_active;
  logic        h_in_pulse;
  logic        v_in_pulse;

  assign h_last     = (h_cnt == H_PERIOD - 1);
  assign v_last     = (v_cnt == V_PERIOD - 1);
  assign h_active   = (h_cnt < H_PIXELS);
  assign v_active   = (v_cnt < V_PIXELS);
  assign h_in_pulse = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
  assign v_in_pulse = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);

  // The vertical counter only moves when the horizontal counter wraps. Lines
  // and frames therefore always have their full length.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 32'd1;
    end else begin
      h_cnt <= h_cnt + 32'd1;
    end
  end

  // The outputs are decoded from the counter values of this cycle. Column and
  // row only load inside the active area, so they keep the last visible
  // coordinate while the raster is in blanking.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      disp_ena    <= 1'b0;
      column      <= '0;
      row         <= '0;
      frame_start <= 1'b0;
    end else begin
      h_sync      <= h_in_pulse ? H_POL : ~H_POL;
      v_sync      <= v_in_pulse ? V_POL : ~V_POL;
      disp_ena    <= h_active && v_active;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      if (h_active) begin
        column <= h_cnt;
      end
      if (v_active) begin
        row <= v_cnt;
      end
    end
  end

endmodule
